// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter: one single-entry buffer per source (ALU, LSU),
// round-robin on contention, registered register-file write port.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_data,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [63:0] wdata,
  output logic [31:0] pending
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 32;

  logic          alu_v_q, alu_v_d;
  logic [RW-1:0] alu_rd_q, alu_rd_d;
  logic [DW-1:0] alu_data_q, alu_data_d;
  logic          lsu_v_q, lsu_v_d;
  logic [RW-1:0] lsu_rd_q, lsu_rd_d;
  logic [DW-1:0] lsu_data_q, lsu_data_d;
  logic          lsu_pri_q, lsu_pri_d;
  logic          wen_q, wen_d;
  logic [RW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          gnt_alu, gnt_lsu, both_full;
  logic [RW-1:0] sel_rd;
  logic [DW-1:0] sel_data;

  // Arbitration looks only at buffered entries; lsu_pri_q says who wins a tie.
  always_comb begin
    both_full = alu_v_q & lsu_v_q;
    gnt_lsu   = lsu_v_q & (~alu_v_q | lsu_pri_q);
    gnt_alu   = alu_v_q & (~lsu_v_q | ~lsu_pri_q);
    sel_rd    = gnt_lsu ? lsu_rd_q : alu_rd_q;
    sel_data  = gnt_lsu ? lsu_data_q : alu_data_q;
  end

  assign alu_ready = ~alu_v_q | gnt_alu;
  assign lsu_ready = ~lsu_v_q | gnt_lsu;

  always_comb begin
    alu_v_d    = alu_v_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    lsu_v_d    = lsu_v_q;
    lsu_rd_d   = lsu_rd_q;
    lsu_data_d = lsu_data_q;
    lsu_pri_d  = lsu_pri_q;
    wen_d      = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;

    if (gnt_alu) alu_v_d = 1'b0;
    if (gnt_lsu) lsu_v_d = 1'b0;
    if (alu_valid && alu_ready) begin
      alu_v_d    = 1'b1;
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
    end
    if (lsu_valid && lsu_ready) begin
      lsu_v_d    = 1'b1;
      lsu_rd_d   = lsu_rd;
      lsu_data_d = lsu_data;
    end

    if (both_full) lsu_pri_d = ~lsu_pri_q;

    // x0 entries are consumed silently; address/data stay zero when idle.
    if ((gnt_alu || gnt_lsu) && (sel_rd != RW'(0))) begin
      wen_d   = 1'b1;
      waddr_d = sel_rd;
      wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_v_q    <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      lsu_v_q    <= 1'b0;
      lsu_rd_q   <= '0;
      lsu_data_q <= '0;
      lsu_pri_q  <= 1'b1;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      alu_v_q    <= alu_v_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      lsu_v_q    <= lsu_v_d;
      lsu_rd_q   <= lsu_rd_d;
      lsu_data_q <= lsu_data_d;
      lsu_pri_q  <= lsu_pri_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  // Destinations of buffered results only; x0 is never reported.
  always_comb begin
    pending = '0;
    if (alu_v_q) pending[alu_rd_q] = 1'b1;
    if (lsu_v_q) pending[lsu_rd_q] = 1'b1;
    pending[0] = 1'b0;
  end

  logic unused_nr;
  assign unused_nr = (NR == 32'd32);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, reset/idle
// sequences, and randomized traffic against a per-source buffer model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [63:0] alu_data, lsu_data;
  logic        wen;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic [31:0] pending;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .pending(pending)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
  endtask

  // Behavioural model: index 0 = ALU, 1 = LSU.
  logic        mv[2];
  logic [4:0]  mrd[2];
  logic [63:0] mdat[2];
  int          last_tie;
  logic        e_wen;
  logic [4:0]  e_waddr;
  logic [63:0] e_wdata;

  task automatic model_reset();
    mv[0] = 1'b0; mv[1] = 1'b0;
    last_tie = 0;
    e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
  endtask

  function automatic int model_grant();
    if (mv[0] && mv[1]) return (last_tie == 1) ? 0 : 1;
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  function automatic logic model_ready(input int s);
    return !mv[s] || (model_grant() == s);
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    for (int s = 0; s < 2; s++)
      if (mv[s] && mrd[s] != 5'd0) p = p | (32'd1 << mrd[s]);
    return p;
  endfunction

  task automatic model_edge();
    int   g;
    logic r0, r1;
    g  = model_grant();
    r0 = model_ready(0);
    r1 = model_ready(1);
    if (mv[0] && mv[1]) last_tie = g;
    if (g >= 0 && mrd[g] != 5'd0) begin
      e_wen = 1'b1; e_waddr = mrd[g]; e_wdata = mdat[g];
    end else begin
      e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
    end
    if (g >= 0) mv[g] = 1'b0;
    if (alu_valid && r0) begin mv[0] = 1'b1; mrd[0] = alu_rd; mdat[0] = alu_data; end
    if (lsu_valid && r1) begin mv[1] = 1'b1; mrd[1] = lsu_rd; mdat[1] = lsu_data; end
  endtask

  typedef struct {
    logic        av;  logic [4:0] ard; logic [63:0] ad;
    logic        lv;  logic [4:0] lrd; logic [63:0] ld;
    logic        ewen; logic [4:0] ewaddr; logic [63:0] ewdata;
    logic        earl; logic elrl; logic [31:0] epend;
  } vec_t;

  vec_t vt[12];

  initial begin
    // Expected outputs are those observed just after the edge that samples the inputs.
    vt[0]  = '{1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 32'h20};
    vt[1]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd5, 64'hDEAD, 1'b1, 1'b1, 32'h0};
    vt[2]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 32'h0};
    vt[3]  = '{1'b1, 5'd3, 64'h11,   1'b1, 5'd4, 64'h22,   1'b0, 5'd0, 64'h0,    1'b0, 1'b1, 32'h18};
    vt[4]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd4, 64'h22,   1'b1, 1'b1, 32'h08};
    vt[5]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd3, 64'h11,   1'b1, 1'b1, 32'h0};
    vt[6]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 5'd7, 64'hA,    1'b1, 5'd7, 64'hB,    1'b0, 5'd0, 64'h0,    1'b1, 1'b0, 32'h80};
    vt[9]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 64'hA,    1'b1, 1'b1, 32'h80};
    vt[10] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 64'hB,    1'b1, 1'b1, 32'h0};
    vt[11] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,    1'b1, 1'b1, 32'h0};

    rst_n = 1'b0;
    drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'hAA);
    #2;
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    @(posedge clk); #2;
    chk("rst_drop_pending", 64'(pending), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ld);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wen", i), 64'(wen), 64'(vt[i].ewen));
      chk($sformatf("vec%0d_waddr", i), 64'(waddr), 64'(vt[i].ewaddr));
      chk($sformatf("vec%0d_wdata", i), wdata, vt[i].ewdata);
      chk($sformatf("vec%0d_alu_ready", i), 64'(alu_ready), 64'(vt[i].earl));
      chk($sformatf("vec%0d_lsu_ready", i), 64'(lsu_ready), 64'(vt[i].elrl));
      chk($sformatf("vec%0d_pending", i), 64'(pending), 64'(vt[i].epend));
    end

    // Idle: nothing written for 10 cycles
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_wen", 64'(wen), 64'd0);
      chk("idle_waddr", 64'(waddr), 64'd0);
      chk("idle_wdata", wdata, 64'd0);
    end

    // Reset mid-flight with both buffers full and a write on the output
    drive(1'b1, 5'd9, 64'h909, 1'b1, 5'd10, 64'hA0A);
    @(posedge clk); #1;
    drive(1'b1, 5'd11, 64'hB0B, 1'b1, 5'd12, 64'hC0C);
    @(posedge clk); #1;
    chk("mid_pre_wen", 64'(wen), 64'd1);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 64'(wen), 64'd0);
    chk("mid_rst_waddr", 64'(waddr), 64'd0);
    chk("mid_rst_wdata", wdata, 64'd0);
    chk("mid_rst_pending", 64'(pending), 64'd0);
    chk("mid_rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("mid_rst_lsu_ready", 64'(lsu_ready), 64'd1);
    drive(1'b1, 5'd13, 64'hD0D, 1'b1, 5'd14, 64'hE0E);
    @(posedge clk); #3;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_wen", 64'(wen), 64'd0);
      chk("post_rst_pending", 64'(pending), 64'd0);
    end

    // Randomized traffic vs model (reset restores LSU tie priority)
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic        av, lv;
      logic [4:0]  ar, lr;
      av = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 3) != 0);
      ar = 5'($urandom_range(0, 31));
      lr = ($urandom_range(0, 7) == 0) ? ar : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) lr = 5'd0;
      drive(av, ar, {$urandom(), $urandom()}, lv, lr, {$urandom(), $urandom()});
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_wen", 64'(wen), 64'(e_wen));
      chk("rnd_waddr", 64'(waddr), 64'(e_waddr));
      chk("rnd_wdata", wdata, e_wdata);
      chk("rnd_pending", 64'(pending), 64'(model_pending()));
      chk("rnd_alu_ready", 64'(alu_ready), 64'(model_ready(0)));
      chk("rnd_lsu_ready", 64'(lsu_ready), 64'(model_ready(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous assertion, active-low.
REQ-003 SHALL have ports alu_valid/alu_ready, input/output, 1/1, ALU result handshake.
REQ-004 SHALL have ports alu_rd/alu_data, input/input, 5/64, ALU destination register and result.
REQ-005 SHALL have ports lsu_valid/lsu_ready, input/output, 1/1, load-unit result handshake.
REQ-006 SHALL have ports lsu_rd/lsu_data, input/input, 5/64, load destination register and data.
REQ-007 SHALL have ports wen/waddr/wdata, output/output/output, 1/5/64, registered register-file write port.
REQ-008 SHALL have port pending, output, 32, bit i set while any buffered result targets register i.

Function
REQ-009 SHALL hold one single-entry buffer per source: valid bit, 5-bit rd, 64-bit data.
REQ-010 SHALL complete a source transfer on a rising edge where that source's valid and ready are both 1.
REQ-011 SHALL drive src_ready = (buffer empty) OR (buffer granted this cycle), combinationally; same-cycle drain and refill SHALL be legal.
REQ-012 SHALL arbitrate combinationally over buffer valid bits only; inputs SHALL never bypass to the output.
REQ-013 SHALL grant the only full buffer when exactly one buffer is full.
REQ-014 SHALL resolve both-full cycles round-robin: grant the source not granted at the last both-full cycle; after reset, the first both-full cycle grants LSU.
REQ-015 SHALL update the round-robin pointer only on both-full cycles.
REQ-016 SHALL load the output register at each edge: on a grant with rd != 0, wen=1, waddr=rd, wdata=data; otherwise wen=0, waddr=0, wdata=0.
REQ-017 SHALL drive waddr=0 and wdata=0 whenever wen=0; the downstream register file forwards on address match alone, so a stale nonzero waddr is a functional bug.
REQ-018 SHALL consume a granted entry with rd=0 (buffer cleared, ready behaviour unchanged) and emit no write.
REQ-019 SHALL have uncontended latency 2 edges: transfer at edge E0, buffer valid after E0, wen=1 after edge E1 for one cycle.
REQ-020 SHALL produce at most one write per cycle; throughput SHALL be one write per cycle with both sources continuously valid.
REQ-021 SHALL compute pending as the OR of one-hot(rd) over full buffers, with bit 0 forced to 0; it SHALL not include the output register.
REQ-022 SHALL allow both sources to target the same rd; write order then follows the grant order and SHALL be observable as two consecutive writes.
REQ-023 SHALL hold a non-granted full buffer's contents stable until granted.

Reset
REQ-024 SHALL, while rst_n=0, immediately clear both buffer valid bits, wen, waddr, wdata, pending, and set the round-robin pointer to favour LSU.
REQ-025 SHALL drive alu_ready=1 and lsu_ready=1 during and after reset; transfers presented while rst_n=0 SHALL be dropped.
REQ-026 SHALL discard buffered results on reset asserted mid-operation, with no partial write emitted.

Verification
REQ-027 Single ALU: alu_valid=1, rd=5, data=0xDEAD at E0 -> wen=1, waddr=5, wdata=0xDEAD after E1 only; pending[5]=1 between E0 and E1.
REQ-028 Collision: both valid at E0 (ALU rd=3/0x11, LSU rd=4/0x22) -> LSU write after E1, ALU write after E2; alu_ready=0 during cycle after E0.
REQ-029 Sustained contention: both valid for 6 edges, distinct rds -> writes alternate LSU, ALU, LSU, ...; one write per cycle; no loss or duplication.
REQ-030 x0 target: lsu_valid, rd=0, data=0xFFFF -> wen, waddr, wdata stay 0; lsu_ready stays 1; pending stays 0.
REQ-031 Reset mid-flight: both buffers full, drop rst_n asynchronously mid-cycle -> wen, pending, and waddr clear immediately; no write after release.
REQ-032 Idle: no valid for 10 cycles -> wen=0, waddr=0, wdata=0 on every cycle.
